pmp_mcast_fork: RTL and testbench
=================================

# pmp_mcast_fork

Clocked, parametrised successor to the 16-way PMP splitter: accepts one transaction on a valid/ready input and delivers it to a selectable subset of N_CH output channels (broadcast or multicast). Each output is released independently ("eager fork"). The input is freed only when every selected channel has accepted. The block sits between the PMP check front end and the per-region PMP entry comparators. It adds:

- per-transaction channel masking;
- a shared data payload;
- a completion pulse;
- a stall watchdog, which the clockless splitter lacks.

## Interface
Parameters:
- N_CH, 16, number of output channels (2..32)
- DW, 32, payload width
- STALL_LIM, 255, cycles a transaction may wait before o_stall asserts (≥1)

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input transaction valid
- o_ready  out  1  input accepted when i_valid & o_ready
- i_data  in  DW  payload
- i_mask  in  N_CH  destination channels; all-ones means broadcast
- o_valid  out  N_CH  per-channel valid
- i_ready  in  N_CH  per-channel ready
- o_data  out  DW  registered payload, shared by all channels
- o_fire  out  1  one-cycle pulse: transaction fully delivered or dropped
- o_drop  out  1  one-cycle pulse: transaction had zero mask
- o_stall  out  1  current transaction pending ≥ STALL_LIM cycles

## Operation
- States are IDLE and SEND.
- Registers:
  - data_q (DW bits)
  - pend_q (N_CH bits)
  - stall counter (saturating at STALL_LIM, width clog2(STALL_LIM+1))
- o_valid = pend_q in SEND, 0 in IDLE.
- o_data = data_q.
- done = (pend_q & ~i_ready) == 0, evaluated in SEND.
- o_ready = !rst & (state==IDLE | done). This is combinational from i_ready, which allows back-to-back transactions.
- Accept (i_valid & o_ready):
  - data_q ← i_data.
  - If i_mask ≠ 0: pend_q ← i_mask, state ← SEND.
  - If i_mask == 0: nothing is stored, o_drop and o_fire pulse next cycle, state stays or goes IDLE.
- In SEND without done: pend_q ← pend_q & ~i_ready. The stall counter increments and saturates.
- In SEND with done:
  - o_fire pulses next cycle.
  - Stall counter clears.
  - If a new accept occurs in the same cycle, state stays SEND with the new mask. Otherwise state goes IDLE.
- o_stall = (counter == STALL_LIM). It stays asserted until the transaction completes.
- Channel k handshake: o_valid[k] & i_ready[k]. Bit k drops the following cycle. o_valid[k] never deasserts before its handshake.
- i_ready[k] on an unselected channel is ignored.
- The upstream source holds i_data and i_mask stable while i_valid & !o_ready.

## Timing
- Reset (asynchronous, immediate) clears everything:
  - state = IDLE
  - pend_q = 0
  - data_q = 0
  - counter = 0
  - o_valid = 0, o_fire = 0, o_drop = 0, o_stall = 0, o_ready = 0
- o_ready rises in the first cycle after rst deasserts.
- Latency:
  - Accept in cycle T gives o_valid in cycle T+1.
  - With all selected i_ready high at T+1, o_fire pulses at T+2.
- Throughput is 1 transaction per cycle when all selected channels are ready.
- Reset mid-transaction: the pending transaction is lost and no o_fire is issued.
- Simultaneous last handshake and new accept: there is no bubble, and o_valid shows the new mask in the next cycle.

## Structure
- Package pmp_fork_pkg holds:
  - the state typedef (IDLE, SEND);
  - default constants for N_CH, DW and STALL_LIM.
- Sub-module pmp_stall_cnt is the saturating counter.
  - Inputs: clk, rst, en, clr.
  - Output: sat.
- Everything else is flat in pmp_mcast_fork.

## Test plan
- Broadcast: N_CH=16, i_mask=16'hFFFF, i_data=32'hA5A5_0001, all i_ready=1.
  - o_valid=FFFF for one cycle.
  - o_fire 2 cycles after accept.
  - o_data=A5A5_0001.
- Staggered accept: i_mask=16'h0105.
  - Ready ch0 at cycle T+1, ch2 at T+3, ch8 at T+6.
  - o_valid drops per bit after each handshake.
  - o_ready=1 only in T+6.
  - o_fire at T+7.
- Zero mask: i_mask=0, accepted in IDLE.
  - o_valid stays 0.
  - o_drop and o_fire both pulse in the next cycle.
- Stall: STALL_LIM=4, mask=16'h0002, i_ready[1]=0 for 10 cycles.
  - o_stall rises after 4 pending cycles and holds.
  - When ready rises, o_fire pulses and o_stall falls in the same cycle.
- Back-to-back: 8 transactions with i_valid held high and all ready.
  - One o_fire per cycle, no bubbles.
  - Data order preserved.
- Reset mid-SEND: assert rst while mask=16'h00F0 is pending.
  - o_valid=0 immediately.
  - No o_fire.
  - First accept after reset behaves as from IDLE.

Source files
------------

// File: rtl/pmp_fork_pkg.sv
// ============================================================================
// Module      : pmp_fork_pkg
// Description : Shared state type and default constants for the PMP multicast fork.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmp_fork_pkg;

  localparam int c_nChDefault      = 16;
  localparam int c_dwDefault       = 32;
  localparam int c_stallLimDefault = 255;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } forkState_e;

  // Width of a counter that must be able to hold the value lim.
  function automatic int cntWidth(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pmp_stall_cnt.sv
// ============================================================================
// Module      : pmp_stall_cnt
// Description : Saturating cycle counter; sat flags that the limit was reached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmp_stall_cnt
  import pmp_fork_pkg::*;
#(
  parameter int STALL_LIM = c_stallLimDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sat
);

  localparam int                c_cntW = cntWidth(STALL_LIM);
  localparam logic [c_cntW-1:0] c_lim  = c_cntW'(STALL_LIM);
  localparam logic [c_cntW-1:0] c_one  = c_cntW'(1);

  logic [c_cntW-1:0] r_cnt;

  // Clear wins over enable so a completing transaction never leaves a residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_lim)) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign sat = (r_cnt == c_lim);

endmodule

`default_nettype wire

// File: rtl/pmp_mcast_fork.sv
// ============================================================================
// Module      : pmp_mcast_fork
// Description : Eager multicast fork; one input transaction to a masked channel set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmp_mcast_fork
  import pmp_fork_pkg::*;
#(
  parameter int N_CH      = c_nChDefault,
  parameter int DW        = c_dwDefault,
  parameter int STALL_LIM = c_stallLimDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [DW-1:0]   i_data,
  input  logic [N_CH-1:0] i_mask,
  output logic [N_CH-1:0] o_valid,
  input  logic [N_CH-1:0] i_ready,
  output logic [DW-1:0]   o_data,
  output logic            o_fire,
  output logic            o_drop,
  output logic            o_stall
);

  forkState_e      r_state;
  forkState_e      w_stateNext;
  logic [DW-1:0]   r_data;
  logic [DW-1:0]   w_dataNext;
  logic [N_CH-1:0] r_pend;
  logic [N_CH-1:0] w_pendNext;
  logic            r_fire;
  logic            r_drop;
  logic            w_fireNext;
  logic            w_dropNext;
  logic            w_done;
  logic            w_accept;
  logic            w_zeroMask;
  logic            w_cntEn;
  logic            w_cntClr;
  logic            w_sat;

  // Ready is combinational from i_ready so a finishing transaction can hand over
  // to the next one in the same cycle.
  assign w_done     = (r_state == SEND) && ((r_pend & ~i_ready) == '0);
  assign o_ready    = !rst && ((r_state == IDLE) || w_done);
  assign w_accept   = i_valid && o_ready;
  assign w_zeroMask = (i_mask == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_pend <= '0;
      r_fire <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_data <= w_dataNext;
      r_pend <= w_pendNext;
      r_fire <= w_fireNext;
      r_drop <= w_dropNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_dataNext  = r_data;
    w_pendNext  = r_pend;
    w_fireNext  = 1'b0;
    w_dropNext  = 1'b0;
    w_cntEn     = 1'b0;
    w_cntClr    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_zeroMask) begin
            w_fireNext = 1'b1;
            w_dropNext = 1'b1;
          end else begin
            w_dataNext  = i_data;
            w_pendNext  = i_mask;
            w_stateNext = SEND;
          end
        end
      end

      SEND: begin
        if (w_done) begin
          w_fireNext  = 1'b1;
          w_cntClr    = 1'b1;
          w_pendNext  = '0;
          w_stateNext = IDLE;
          if (w_accept) begin
            if (w_zeroMask) begin
              w_dropNext = 1'b1;
            end else begin
              w_dataNext  = i_data;
              w_pendNext  = i_mask;
              w_stateNext = SEND;
            end
          end
        end else begin
          // Retire each channel individually as its handshake completes.
          w_pendNext = r_pend & ~i_ready;
          w_cntEn    = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_pendNext  = '0;
      end
    endcase
  end

  pmp_stall_cnt #(
    .STALL_LIM (STALL_LIM)
  ) u_stallCnt (
    .clk (clk),
    .rst (rst),
    .en  (w_cntEn),
    .clr (w_cntClr),
    .sat (w_sat)
  );

  assign o_valid = (r_state == SEND) ? r_pend : '0;
  assign o_data  = r_data;
  assign o_fire  = r_fire;
  assign o_drop  = r_drop;
  assign o_stall = w_sat;

endmodule

`default_nettype wire

// File: tb/tb_pmp_mcast_fork.sv
// ============================================================================
// Module      : tb_pmp_mcast_fork
// Description : Scoreboard bench for pmp_mcast_fork with a cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmp_mcast_fork;

  localparam int NCH = 16;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic           clk     = 1'b0;
  logic           rst     = 1'b1;
  logic           i_valid = 1'b0;
  logic [DW-1:0]  i_data  = '0;
  logic [NCH-1:0] i_mask  = '0;
  logic [NCH-1:0] i_ready = '0;
  logic           o_ready;
  logic [NCH-1:0] o_valid;
  logic [DW-1:0]  o_data;
  logic           o_fire;
  logic           o_drop;
  logic           o_stall;

  pmp_mcast_fork #(
    .N_CH      (NCH),
    .DW        (DW),
    .STALL_LIM (LIM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_mask  (i_mask),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_fire  (o_fire),
    .o_drop  (o_drop),
    .o_stall (o_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [NCH-1:0] mask;
  } txn_t;

  txn_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, evaluated between edges where all inputs are settled.
  logic [NCH-1:0] mPend = '0;
  logic [DW-1:0]  mData = '0;
  logic           mFire = 1'b0;
  logic           mDrop = 1'b0;
  int             mCnt  = 0;

  always @(negedge clk) begin : monitor
    logic mDone;
    logic mReady;
    txn_t t;
    if (rst) begin
      checkVal("rst_valid", 32'(o_valid), 32'd0);
      checkVal("rst_ready", 32'(o_ready), 32'd0);
      checkVal("rst_fire",  32'(o_fire),  32'd0);
      checkVal("rst_drop",  32'(o_drop),  32'd0);
      checkVal("rst_stall", 32'(o_stall), 32'd0);
      mPend = '0;
      mFire = 1'b0;
      mDrop = 1'b0;
      mCnt  = 0;
      sbQ.delete();
    end else begin
      checkVal("o_valid", 32'(o_valid), 32'(mPend));
      if (mPend != '0) checkVal("o_data", o_data, mData);
      checkVal("o_fire",  32'(o_fire),  32'(mFire));
      checkVal("o_drop",  32'(o_drop),  32'(mDrop));
      checkVal("o_stall", 32'(o_stall), (mCnt >= LIM) ? 32'd1 : 32'd0);
      mDone  = (mPend != '0) && ((mPend & ~i_ready) == '0);
      mReady = (mPend == '0) || mDone;
      checkVal("o_ready", 32'(o_ready), 32'(mReady));
      mFire = mDone;
      mDrop = 1'b0;
      if (mPend != '0) begin
        if (mDone) mCnt = 0;
        else if (mCnt < LIM) mCnt++;
      end
      mPend = mPend & ~i_ready;
      if (i_valid && mReady) begin
        if (sbQ.size() == 0) begin
          checkVal("sb_empty", 32'd0, 32'd1);
        end else begin
          t = sbQ.pop_front();
          if (t.mask == '0) begin
            mFire = 1'b1;
            mDrop = 1'b1;
          end else begin
            mPend = t.mask;
            mData = t.data;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents a transaction and returns just after the edge that accepted it.
  task automatic drive(input logic [DW-1:0] d, input logic [NCH-1:0] m);
    int n;
    sbQ.push_back({d, m});
    i_data  = d;
    i_mask  = m;
    i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) checkVal("accept_timeout", 32'd0, 32'd1);
    cyc();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1;
    checkVal("rst_ready_t0", 32'(o_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Broadcast
    i_ready = '1;
    drive(32'hA5A5_0001, 16'hFFFF);
    i_valid = 1'b0;
    repeat (3) cyc();

    // Staggered per-channel acceptance
    i_ready = '0;
    drive(32'h0000_0105, 16'h0105);
    i_valid = 1'b0;
    i_ready = 16'h0001; cyc();
    i_ready = 16'h0000; cyc();
    i_ready = 16'h0004; cyc();
    i_ready = 16'h0000; cyc();
    cyc();
    i_ready = 16'h0100; cyc();
    i_ready = 16'h0000;
    repeat (2) cyc();

    // Zero mask is dropped
    drive(32'hDEAD_0000, 16'h0000);
    i_valid = 1'b0;
    repeat (2) cyc();

    // Stall watchdog; unselected readies must be ignored
    i_ready = 16'hFFFD;
    drive(32'h5747_0002, 16'h0002);
    i_valid = 1'b0;
    repeat (10) cyc();
    i_ready = '1;
    repeat (3) cyc();

    // Back-to-back with varied masks
    i_ready = '1;
    for (int i = 0; i < 8; i++) begin
      drive(32'hB000_0000 + 32'(i), (16'h0001 << i) | 16'h8000);
    end
    i_valid = 1'b0;
    repeat (3) cyc();

    // Handover while the next request is already waiting
    i_ready = '0;
    drive(32'hC100_0003, 16'h0003);
    sbQ.push_back({32'hC200_0040, 16'h0040});
    i_data  = 32'hC200_0040;
    i_mask  = 16'h0040;
    i_ready = 16'h0001; cyc();
    i_ready = 16'h0002; cyc();
    i_valid = 1'b0;
    i_ready = 16'h0040;
    repeat (3) cyc();

    // Reset while a transaction is pending
    i_ready = '0;
    drive(32'h0000_C0DE, 16'h00F0);
    i_valid = 1'b0;
    cyc();
    #2 rst = 1'b1;
    #1;
    checkVal("rst_mid_valid", 32'(o_valid), 32'd0);
    checkVal("rst_mid_ready", 32'(o_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    i_ready = '1;
    drive(32'h1234_0010, 16'h0010);
    i_valid = 1'b0;
    repeat (4) cyc();

    checkVal("sb_drain", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
